// File: rtl/fu_pkg.sv
// Shared definitions for the pipelined functional unit: opcode encodings
// and the operand-routing table used by the decode stage.
package fu_pkg;

  localparam logic [2:0] OP_ADD    = 3'd0;
  localparam logic [2:0] OP_ADDN   = 3'd1;
  localparam logic [2:0] OP_AND    = 3'd2;
  localparam logic [2:0] OP_OR     = 3'd3;
  localparam logic [2:0] OP_MAX    = 3'd4;
  localparam logic [2:0] OP_MIN    = 3'd5;
  localparam logic [2:0] OP_SHRADD = 3'd6;
  localparam logic [2:0] OP_SHLADD = 3'd7;

  typedef enum logic [1:0] {
    SRC_A = 2'd0,
    SRC_B = 2'd1,
    SRC_C = 2'd2
  } src_e;

  typedef struct packed {
    src_e x_src;
    src_e y_src;
  } operand_sel_t;

  // Routing is width-independent, so the table returns source selectors
  // and the datapath does the actual muxing.
  function automatic operand_sel_t operand_select(input logic [2:0] op);
    operand_sel_t sel;
    case (op)
      OP_SHLADD: sel = '{x_src: SRC_C, y_src: SRC_A};
      OP_SHRADD: sel = '{x_src: SRC_A, y_src: SRC_B};
      OP_MIN:    sel = '{x_src: SRC_A, y_src: SRC_C};
      OP_MAX:    sel = '{x_src: SRC_C, y_src: SRC_A};
      OP_OR:     sel = '{x_src: SRC_B, y_src: SRC_C};
      default:   sel = '{x_src: SRC_C, y_src: SRC_A};
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/fu_priority_encoder.sv
// Combinational priority encoder: reports the index of the highest set
// request bit, plus a flag when no bit is set.
module fu_priority_encoder #(
  parameter int OPC_W = 3
) (
  input  logic [2**OPC_W-1:0] req,
  output logic [OPC_W-1:0]    code,
  output logic                none
);

  // Ascending scan so later (higher) bits overwrite lower ones.
  always_comb begin
    code = '0;
    for (int i = 0; i < 2**OPC_W; i++) begin
      if (req[i]) code = OPC_W'(i);
    end
    none = (req == '0);
  end

endmodule

// File: rtl/pipelined_functional_unit.sv
// Two-stage functional unit: decode (priority encode + operand select)
// then execute, with valid/ready handshakes on both sides.
module pipelined_functional_unit
  import fu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPC_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2**OPC_W-1:0] instruction,
  input  logic [WIDTH-1:0]    A,
  input  logic [WIDTH-1:0]    B,
  input  logic [WIDTH-1:0]    C,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    F,
  output logic [OPC_W-1:0]    op_out,
  output logic                zero,
  output logic                carry,
  output logic                illegal
);

  logic [OPC_W-1:0] dec_code;
  logic             dec_none;
  operand_sel_t     dec_sel;

  logic             s1_valid;
  logic [OPC_W-1:0] s1_op;
  logic [WIDTH-1:0] s1_x;
  logic [WIDTH-1:0] s1_y;
  logic             s1_illegal;

  logic             s2_advance;
  logic             in_fire;

  logic [WIDTH:0]   ex_sum;
  logic [WIDTH-1:0] ex_res;
  logic             ex_carry;

  fu_priority_encoder #(.OPC_W(OPC_W)) u_prio (
    .req  (instruction),
    .code (dec_code),
    .none (dec_none)
  );

  assign dec_sel    = operand_select(3'(dec_code));
  assign s2_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s2_advance;
  assign in_fire    = in_valid && in_ready;

  function automatic logic [WIDTH-1:0] pick(input src_e src,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] c);
    case (src)
      SRC_A:   return a;
      SRC_B:   return b;
      default: return c;
    endcase
  endfunction

  // Decode stage; an all-zero instruction runs as op 0 flagged illegal.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_op      <= '0;
      s1_x       <= '0;
      s1_y       <= '0;
      s1_illegal <= 1'b0;
    end else if (in_fire) begin
      s1_valid   <= 1'b1;
      s1_op      <= dec_none ? '0 : dec_code;
      s1_x       <= pick(dec_sel.x_src, A, B, C);
      s1_y       <= pick(dec_sel.y_src, A, B, C);
      s1_illegal <= dec_none;
    end else if (s2_advance) begin
      s1_valid <= 1'b0;
    end
  end

  // Shifted operands are truncated to WIDTH bits inside the concatenation
  // before the add, so only the sum itself can produce a carry.
  always_comb begin
    ex_sum   = '0;
    ex_res   = '0;
    ex_carry = 1'b0;
    case (3'(s1_op))
      OP_SHLADD: ex_sum = {1'b0, s1_x << 1} + {1'b0, s1_y};
      OP_SHRADD: ex_sum = {1'b0, s1_x >> 1} + {1'b0, s1_y};
      OP_ADDN:   ex_sum = {1'b0, s1_x} + {1'b0, ~s1_y};
      OP_ADD:    ex_sum = {1'b0, s1_x} + {1'b0, s1_y};
      default:   ex_sum = '0;
    endcase
    case (3'(s1_op))
      OP_MIN:  ex_res = (s1_x < s1_y) ? s1_x : s1_y;
      OP_MAX:  ex_res = (s1_x > s1_y) ? s1_x : s1_y;
      OP_OR:   ex_res = s1_x | s1_y;
      OP_AND:  ex_res = s1_x & s1_y;
      default: begin
        ex_res   = ex_sum[WIDTH-1:0];
        ex_carry = ex_sum[WIDTH];
      end
    endcase
  end

  // Result registers only load when stage 1 hands over, so a stalled
  // output holds F and the flags steady.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      F         <= '0;
      op_out    <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      illegal   <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        F       <= ex_res;
        op_out  <= s1_op;
        zero    <= (ex_res == '0);
        carry   <= ex_carry;
        illegal <= s1_illegal;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_functional_unit.sv
// Scoreboard bench for pipelined_functional_unit: expected results are
// queued at issue and compared when the unit delivers them.
module tb_pipelined_functional_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] instruction;
  logic [7:0] A, B, C;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] F;
  logic [2:0] op_out;
  logic       zero, carry, illegal;

  typedef struct {
    logic [7:0] f;
    logic [2:0] op;
    logic       z;
    logic       c;
    logic       ill;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipelined_functional_unit #(.WIDTH(8), .OPC_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instruction (instruction),
    .A           (A),
    .B           (B),
    .C           (C),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .F           (F),
    .op_out      (op_out),
    .zero        (zero),
    .carry       (carry),
    .illegal     (illegal)
  );

  // Reference model written with integer arithmetic.
  function automatic exp_t model(input logic [7:0] ins, input logic [7:0] a,
                                 input logic [7:0] b, input logic [7:0] c);
    exp_t e;
    int op = 0;
    int x, y, s;
    for (int i = 0; i < 8; i++) if (ins[i]) op = i;
    case (op)
      7: begin x = c; y = a; end
      6: begin x = a; y = b; end
      5: begin x = a; y = c; end
      4: begin x = c; y = a; end
      3: begin x = b; y = c; end
      default: begin x = c; y = a; end
    endcase
    case (op)
      7: s = ((x * 2) % 256) + y;
      6: s = (x / 2) + y;
      5: s = (x < y) ? x : y;
      4: s = (x > y) ? x : y;
      3: s = x | y;
      2: s = x & y;
      1: s = x + (255 - y);
      default: s = x + y;
    endcase
    e.f   = 8'(s % 256);
    e.op  = 3'(op);
    e.z   = (s % 256) == 0;
    e.c   = (op == 0 || op == 1 || op == 6 || op == 7) && (s >= 256);
    e.ill = (ins == 8'h00);
    return e;
  endfunction

  // Presents one instruction and returns just after the accepting edge;
  // in_valid is left high so callers can stream back to back.
  task automatic send(input logic [7:0] ins, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] c);
    int waited = 0;
    instruction = ins; A = a; B = b; C = c;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("[TB] FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end else begin
      @(posedge clk);
      sb.push_back(model(ins, a, b, c));
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    instruction = '0; A = '0; B = '0; C = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, F, op_out, zero, carry, illegal} !== {1'b0, 1'b1, 8'h00, 3'd0, 3'b000}) begin
      errors++;
      $display("[TB] FAIL reset_state: got ov=%0b ir=%0b F=%h op=%0d z=%0b c=%0b ill=%0b required ov=0 ir=1 F=00 op=0 flags=0",
               out_valid, in_ready, F, op_out, zero, carry, illegal);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [7:0] vins[12] = '{8'h80, 8'h03, 8'h03, 8'h20, 8'h10, 8'h00, 8'h40, 8'h40, 8'h08, 8'h04, 8'h01, 8'h81};
    logic [7:0] va[12]   = '{8'h30, 8'h03, 8'h03, 8'h90, 8'h90, 8'h01, 8'h81, 8'hFF, 8'h00, 8'h0F, 8'h10, 8'h01};
    logic [7:0] vb[12]   = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h90, 8'h0C, 8'h00, 8'h00, 8'h00};
    logic [7:0] vc[12]   = '{8'h50, 8'h05, 8'h03, 8'h10, 8'h10, 8'hFF, 8'h00, 8'h00, 8'h30, 8'h3C, 8'hF0, 8'h80};
    logic [7:0] vf[12]   = '{8'hD0, 8'h01, 8'hFF, 8'h10, 8'h90, 8'h00, 8'hBF, 8'h0F, 8'h3C, 8'h0C, 8'h00, 8'h01};
    logic       vcy[12]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_t e;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(vins[i], va[i], vb[i], vc[i]);
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL early_valid[%0d]: out_valid=%0b required 0", i, out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL latency[%0d]: out_valid=%0b required 1", i, out_valid);
      end else begin
        e = sb.pop_front();
        checks++;
        if ({F, op_out, zero, carry, illegal} !== {e.f, e.op, e.z, e.c, e.ill}) begin
          errors++;
          $display("[TB] FAIL result[%0d]: got F=%h op=%0d z=%0b c=%0b ill=%0b required F=%h op=%0d z=%0b c=%0b ill=%0b",
                   i, F, op_out, zero, carry, illegal, e.f, e.op, e.z, e.c, e.ill);
        end
        checks++;
        if ({F, carry} !== {vf[i], vcy[i]}) begin
          errors++;
          $display("[TB] FAIL table[%0d]: got F=%h c=%0b required F=%h c=%0b", i, F, carry, vf[i], vcy[i]);
        end
      end
      @(posedge clk); #1;
    end
    sb.delete();
  endtask

  task automatic test_back_to_back();
    int   got = 0;
    logic [7:0] held_f;
    exp_t e;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(8'($urandom_range(0, 255)), 8'($urandom), 8'($urandom), 8'($urandom));
        in_valid = 1'b0;
      end
      begin
        held_f = '0;
        for (int cyc = 0; cyc < 80 && got < 6; cyc++) begin
          out_ready = !(cyc >= 4 && cyc <= 6);
          @(negedge clk);
          if (!out_ready) begin
            if (cyc == 4) held_f = F;
            checks++;
            if (out_valid !== 1'b1 || (cyc > 4 && F !== held_f)) begin
              errors++;
              $display("[TB] FAIL stall_hold[c%0d]: ov=%0b F=%h required ov=1 F=%h", cyc, out_valid, F, held_f);
            end
            if (cyc >= 5) begin
              checks++;
              if (in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_in_ready[c%0d]: in_ready=%0b required 0", cyc, in_ready);
              end
            end
          end else if (out_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
              errors++;
              $display("[TB] FAIL b2b_extra: unexpected result F=%h", F);
            end else begin
              e = sb.pop_front();
              got++;
              if ({F, op_out, zero, carry, illegal} !== {e.f, e.op, e.z, e.c, e.ill}) begin
                errors++;
                $display("[TB] FAIL b2b_result[%0d]: got F=%h op=%0d z=%0b c=%0b ill=%0b required F=%h op=%0d z=%0b c=%0b ill=%0b",
                         got, F, op_out, zero, carry, illegal, e.f, e.op, e.z, e.c, e.ill);
              end
            end
          end
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    checks++;
    if (got != 6 || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL b2b_count: got=%0d pending=%0d required got=6 pending=0", got, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b0;
    send(8'h01, 8'h11, 8'h22, 8'h33);
    send(8'h80, 8'h44, 8'h55, 8'h66);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    sb.delete();
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, F} !== {1'b0, 1'b1, 8'h00}) begin
      errors++;
      $display("[TB] FAIL flush_state: ov=%0b ir=%0b F=%h required ov=0 ir=1 F=00", out_valid, in_ready, F);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL flush_leak[%0d]: out_valid=%0b F=%h required 0", k, out_valid, F);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
